// File: rtl/execute_result_stage.sv
// Execute result stage: selects the unit result for each instruction, holds it in a
// two-entry skid buffer (head + skid) and hands it downstream over valid/ready.
// Also answers a forwarding lookup over both buffered entries and counts retirements.
module execute_result_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_flush,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [1:0]                i_result_select,
  input  logic [DATA_WIDTH-1:0]     i_logic_result,
  input  logic [DATA_WIDTH-1:0]     i_adder_result,
  input  logic [DATA_WIDTH-1:0]     i_shift_result,
  input  logic [DATA_WIDTH-1:0]     i_link_value,
  input  logic [REG_ADDR_WIDTH-1:0] i_dest_reg,
  input  logic                      i_write_enable,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [DATA_WIDTH-1:0]     o_out_data,
  output logic [REG_ADDR_WIDTH-1:0] o_out_dest_reg,
  output logic                      o_out_write_enable,
  input  logic [REG_ADDR_WIDTH-1:0] i_lookup_reg,
  output logic                      o_lookup_hit,
  output logic [DATA_WIDTH-1:0]     o_lookup_data,
  output logic [31:0]               o_retired_count
);

  logic                      r_head_valid;
  logic [DATA_WIDTH-1:0]     r_head_data;
  logic [REG_ADDR_WIDTH-1:0] r_head_dest;
  logic                      r_head_we;

  logic                      r_skid_valid;
  logic [DATA_WIDTH-1:0]     r_skid_data;
  logic [REG_ADDR_WIDTH-1:0] r_skid_dest;
  logic                      r_skid_we;

  logic [31:0]               r_retired_count;

  logic [DATA_WIDTH-1:0]     w_in_data;
  logic                      w_in_we;
  logic                      w_accept;
  logic                      w_drain;
  logic                      w_head_free;

  // in_ready comes straight from the skid flop so the upstream path is registered
  assign o_in_ready  = ~r_skid_valid;
  assign w_accept    = i_in_valid & o_in_ready;
  assign w_drain     = r_head_valid & i_out_ready;
  assign w_head_free = ~r_head_valid | w_drain;

  // Pick the unit result; r0 is hardwired so its write enable is dropped at capture
  always_comb begin
    w_in_data = '0;
    unique case (i_result_select)
      2'b00: w_in_data = i_logic_result;
      2'b01: w_in_data = i_adder_result;
      2'b10: w_in_data = i_shift_result;
      2'b11: w_in_data = i_link_value;
      default: w_in_data = '0;
    endcase
    w_in_we = i_write_enable & (i_dest_reg != '0);
  end

  // Head entry: refilled from skid first (FIFO order), else from input, else emptied
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_head_valid <= 1'b0;
      r_head_data  <= '0;
      r_head_dest  <= '0;
      r_head_we    <= 1'b0;
    end else if (i_flush) begin
      r_head_valid <= 1'b0;
      r_head_data  <= '0;
      r_head_dest  <= '0;
      r_head_we    <= 1'b0;
    end else if (w_head_free) begin
      if (r_skid_valid) begin
        r_head_valid <= 1'b1;
        r_head_data  <= r_skid_data;
        r_head_dest  <= r_skid_dest;
        r_head_we    <= r_skid_we;
      end else if (w_accept) begin
        r_head_valid <= 1'b1;
        r_head_data  <= w_in_data;
        r_head_dest  <= i_dest_reg;
        r_head_we    <= w_in_we;
      end else begin
        r_head_valid <= 1'b0;
        r_head_data  <= '0;
        r_head_dest  <= '0;
        r_head_we    <= 1'b0;
      end
    end
  end

  // Skid entry: catches an accepted input while the head is occupied and stalled
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_dest  <= '0;
      r_skid_we    <= 1'b0;
    end else if (i_flush || (w_head_free && r_skid_valid)) begin
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_dest  <= '0;
      r_skid_we    <= 1'b0;
    end else if (w_accept && !w_head_free) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= w_in_data;
      r_skid_dest  <= i_dest_reg;
      r_skid_we    <= w_in_we;
    end
  end

  // Retirement counter; a drain coinciding with a flush still retires
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_retired_count <= '0;
    end else if (w_drain) begin
      r_retired_count <= r_retired_count + 32'd1;
    end
  end

  // Forwarding lookup; the skid entry is newer so it overrides a head match
  always_comb begin
    o_lookup_hit  = 1'b0;
    o_lookup_data = '0;
    if (i_lookup_reg != '0) begin
      if (r_head_valid && r_head_we && (r_head_dest == i_lookup_reg)) begin
        o_lookup_hit  = 1'b1;
        o_lookup_data = r_head_data;
      end
      if (r_skid_valid && r_skid_we && (r_skid_dest == i_lookup_reg)) begin
        o_lookup_hit  = 1'b1;
        o_lookup_data = r_skid_data;
      end
    end
  end

  assign o_out_valid        = r_head_valid;
  assign o_out_data         = r_head_data;
  assign o_out_dest_reg     = r_head_dest;
  assign o_out_write_enable = r_head_we;
  assign o_retired_count    = r_retired_count;

endmodule
